// File: rtl/mul_final_adder.sv
// Carry-propagate stage of the 32x32 multiplier: two registered halves with a valid/ready handshake.
// Optional retired-op counter enabled by defining MUL_FA_PERF_CNT_EN.
module mul_final_adder #(
   parameter int W     = 64,
   parameter int TAG_W = 5
) (
   input  logic             mul_clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_s,
   input  logic [W-1:0]     in_c,
   input  logic             in_cin,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W/2-1:0]   out_result,
   output logic [TAG_W-1:0] out_tag
`ifdef MUL_FA_PERF_CNT_EN
   ,
   output logic [31:0]      perf_retired
`endif
);

   localparam int H = W / 2;

   logic             v_a;
   logic             v_b;
   logic [H-1:0]     a_lo;
   logic             a_k;
   logic [H-1:0]     a_s_hi;
   logic [H-1:0]     a_c_hi;
   logic [1:0]       a_op;
   logic [TAG_W-1:0] a_tag;

   logic             adv_b;
   logic             accept_en;
   logic             adv_b_en;
   logic [H:0]       lo_sum;
   logic [H-1:0]     hi_sum;
   logic             sel_hi;

   // Stage B may take stage A's op when it is empty or being drained this cycle
   assign adv_b     = v_a && (!v_b || out_ready);
   assign in_ready  = !v_a || adv_b;
   assign accept_en = in_valid && in_ready && !flush;
   assign adv_b_en  = adv_b && !flush;
   assign out_valid = v_b;

   assign lo_sum = {1'b0, in_s[H-1:0]} + {1'b0, in_c[H-2:0], in_cin};
   assign hi_sum = a_s_hi + a_c_hi + {{(H-1){1'b0}}, a_k};
   assign sel_hi = (a_op == 2'b01) || (a_op == 2'b10);

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         v_a <= 1'b0;
         v_b <= 1'b0;
      end else if (flush) begin
         v_a <= 1'b0;
         v_b <= 1'b0;
      end else begin
         if (accept_en)
            v_a <= 1'b1;
         else if (adv_b)
            v_a <= 1'b0;
         if (adv_b)
            v_b <= 1'b1;
         else if (out_ready)
            v_b <= 1'b0;
      end
   end

   // Stage A holds the finished low half plus the raw upper-half operands
   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         a_lo   <= '0;
         a_k    <= 1'b0;
         a_s_hi <= '0;
         a_c_hi <= '0;
         a_op   <= '0;
         a_tag  <= '0;
      end else if (accept_en) begin
         a_lo   <= lo_sum[H-1:0];
         a_k    <= lo_sum[H];
         a_s_hi <= in_s[W-1:H];
         a_c_hi <= in_c[W-2:H-1];
         a_op   <= in_op;
         a_tag  <= in_tag;
      end
   end

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         out_result <= '0;
         out_tag    <= '0;
      end else if (adv_b_en) begin
         out_result <= sel_hi ? hi_sum : a_lo;
         out_tag    <= a_tag;
      end
   end

`ifdef MUL_FA_PERF_CNT_EN
   logic [31:0] perf_cnt;

   // Survives flush on purpose; only reset clears it
   always_ff @(posedge mul_clk) begin
      if (!resetn)
         perf_cnt <= '0;
      else if (v_b && out_ready)
         perf_cnt <= perf_cnt + 32'd1;
   end

   assign perf_retired = perf_cnt;
`endif

endmodule

// File: tb/tb_mul_final_adder.sv
// Directed bench for mul_final_adder: vector table plus backpressure, flush and reset sequences.
// Perf counter checks compile only when MUL_FA_PERF_CNT_EN is defined.
module tb_mul_final_adder;

   logic        mul_clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_s;
   logic [63:0] in_c;
   logic        in_cin;
   logic [1:0]  in_op;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
`ifdef MUL_FA_PERF_CNT_EN
   logic [31:0] perf_retired;
`endif

   int applied = 0;
   int miscompares = 0;

   always #5 mul_clk = ~mul_clk;

   mul_final_adder #(.W(64), .TAG_W(5)) dut (
      .mul_clk(mul_clk),
      .resetn(resetn),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_s(in_s),
      .in_c(in_c),
      .in_cin(in_cin),
      .in_op(in_op),
      .in_tag(in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_result(out_result),
      .out_tag(out_tag)
`ifdef MUL_FA_PERF_CNT_EN
      ,
      .perf_retired(perf_retired)
`endif
   );

   typedef struct {
      logic [63:0] s;
      logic [63:0] c;
      logic        cin;
      logic [1:0]  op;
      logic [4:0]  tag;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge mul_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [63:0] s, input logic [63:0] c,
                                input logic cin, input logic [1:0] op, input logic [4:0] tag);
      in_valid = v;
      in_s     = s;
      in_c     = c;
      in_cin   = cin;
      in_op    = op;
      in_tag   = tag;
   endtask

   initial begin
      vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 2'b01, 5'd20, 32'h0000_0001};
      vecs[1] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 2'b00, 5'd21, 32'h0000_0000};
      vecs[2] = '{64'h0, 64'h1, 1'b0, 2'b00, 5'd22, 32'h0000_0002};
      vecs[3] = '{64'h0, 64'h8000_0000_0000_0000, 1'b0, 2'b10, 5'd23, 32'h0000_0000};
      vecs[4] = '{64'h1234_5678_0000_0010, 64'h8, 1'b1, 2'b11, 5'd24, 32'h0000_0021};
      vecs[5] = '{64'h0, 64'h0000_0000_8000_0000, 1'b0, 2'b01, 5'd25, 32'h0000_0001};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 2'b10, 5'd26, 32'h0000_0000};
      vecs[7] = '{64'h1111_1111_2222_2222, 64'h0101_0101_0101_0101, 1'b1, 2'b10, 5'd27, 32'h1313_1313};
      vecs[8] = '{64'h1111_1111_2222_2222, 64'h0101_0101_0101_0101, 1'b1, 2'b00, 5'd28, 32'h2424_2425};

      resetn = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
      step();
      step();
      resetn = 1'b1;
      checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("reset_out_result", {32'b0, out_result}, 64'd0);
      checkOutput("reset_out_tag", {59'b0, out_tag}, 64'd0);
      checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);

      // One op at a time: nothing after the accept edge, result after the next
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, vecs[i].s, vecs[i].c, vecs[i].cin, vecs[i].op, vecs[i].tag);
         step();
         applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
         checkOutput($sformatf("vec%0d_latency", i), {63'b0, out_valid}, 64'd0);
         step();
         checkOutput($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'd1);
         checkOutput($sformatf("vec%0d_result", i), {32'b0, out_result}, {32'b0, vecs[i].exp});
         checkOutput($sformatf("vec%0d_tag", i), {59'b0, out_tag}, {59'b0, vecs[i].tag});
      end
      step();
      checkOutput("drain_valid", {63'b0, out_valid}, 64'd0);

      // Back-to-back stream, one result per cycle
      for (int c = 0; c < 5; c++) begin
         if (c < 4)
            applyStimulus(1'b1, 64'(c + 100), 64'h0, 1'b0, 2'b00, 5'(10 + c));
         else
            applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
         step();
         if (c >= 1) begin
            checkOutput($sformatf("stream%0d_valid", c), {63'b0, out_valid}, 64'd1);
            checkOutput($sformatf("stream%0d_tag", c), {59'b0, out_tag}, 64'(10 + c - 1));
            checkOutput($sformatf("stream%0d_result", c), {32'b0, out_result}, 64'(100 + c - 1));
         end
      end
      step();
      checkOutput("stream_drain", {63'b0, out_valid}, 64'd0);

      // Backpressure: two ops fill the pipe, the third waits at the input
      out_ready = 1'b0;
      applyStimulus(1'b1, 64'd1, 64'h0, 1'b0, 2'b00, 5'd1);
      step();
      checkOutput("bp_ready_after1", {63'b0, in_ready}, 64'd1);
      applyStimulus(1'b1, 64'd2, 64'h0, 1'b0, 2'b00, 5'd2);
      step();
      checkOutput("bp_ready_after2", {63'b0, in_ready}, 64'd0);
      applyStimulus(1'b1, 64'd3, 64'h0, 1'b0, 2'b00, 5'd3);
      for (int k = 0; k < 3; k++) begin
         step();
         checkOutput($sformatf("bp_hold%0d_ready", k), {63'b0, in_ready}, 64'd0);
         checkOutput($sformatf("bp_hold%0d_tag", k), {59'b0, out_tag}, 64'd1);
         checkOutput($sformatf("bp_hold%0d_result", k), {32'b0, out_result}, 64'd1);
      end
      out_ready = 1'b1;
      step();
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
      checkOutput("bp_deliver_tag2", {59'b0, out_tag}, 64'd2);
      checkOutput("bp_deliver_valid2", {63'b0, out_valid}, 64'd1);
      step();
      checkOutput("bp_deliver_tag3", {59'b0, out_tag}, 64'd3);
      checkOutput("bp_deliver_result3", {32'b0, out_result}, 64'd3);
      step();
      checkOutput("bp_empty", {63'b0, out_valid}, 64'd0);

      // Flush with both stages full and a new op presented in the same cycle
      out_ready = 1'b0;
      applyStimulus(1'b1, 64'd4, 64'h0, 1'b0, 2'b00, 5'd4);
      step();
      applyStimulus(1'b1, 64'd5, 64'h0, 1'b0, 2'b00, 5'd5);
      step();
      applyStimulus(1'b1, 64'd6, 64'h0, 1'b0, 2'b00, 5'd6);
      flush = 1'b1;
      step();
      flush = 1'b0;
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
      checkOutput("flush_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("flush_in_ready", {63'b0, in_ready}, 64'd1);
      out_ready = 1'b1;
      step();
      checkOutput("flush_dropped", {63'b0, out_valid}, 64'd0);
      applyStimulus(1'b1, 64'd7, 64'h0, 1'b0, 2'b00, 5'd7);
      step();
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
      checkOutput("post_flush_latency", {63'b0, out_valid}, 64'd0);
      step();
      checkOutput("post_flush_valid", {63'b0, out_valid}, 64'd1);
      checkOutput("post_flush_tag", {59'b0, out_tag}, 64'd7);
      checkOutput("post_flush_result", {32'b0, out_result}, 64'd7);
      step();

      // Reset while both stages hold work
      out_ready = 1'b0;
      applyStimulus(1'b1, 64'd8, 64'h0, 1'b0, 2'b00, 5'd8);
      step();
      applyStimulus(1'b1, 64'd9, 64'h0, 1'b0, 2'b00, 5'd9);
      step();
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
      checkOutput("prereset_in_ready", {63'b0, in_ready}, 64'd0);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      checkOutput("midreset_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("midreset_result", {32'b0, out_result}, 64'd0);
      checkOutput("midreset_tag", {59'b0, out_tag}, 64'd0);
      checkOutput("midreset_in_ready", {63'b0, in_ready}, 64'd1);
      out_ready = 1'b1;
      step();
      checkOutput("midreset_stays_empty", {63'b0, out_valid}, 64'd0);

`ifdef MUL_FA_PERF_CNT_EN
      checkOutput("perf_after_reset", {32'b0, perf_retired}, 64'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 64'(i), 64'h0, 1'b0, 2'b00, 5'(i));
         step();
         applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
         step();
      end
      step();
      applyStimulus(1'b1, 64'd30, 64'h0, 1'b0, 2'b00, 5'd30);
      step();
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      checkOutput("perf_ten_retired", {32'b0, perf_retired}, 64'd10);
      out_ready = 1'b0;
      force dut.perf_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.perf_cnt;
      out_ready = 1'b1;
      applyStimulus(1'b1, 64'd31, 64'h0, 1'b0, 2'b00, 5'd31);
      step();
      applyStimulus(1'b0, 64'h0, 64'h0, 1'b0, 2'b00, 5'd0);
      step();
      checkOutput("perf_preload_hold", {32'b0, perf_retired}, 64'hFFFF_FFFF);
      step();
      checkOutput("perf_wrap", {32'b0, perf_retired}, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
